// File: rtl/fcims_multi.sv
// Multi-item inventory/checkout engine: restock, sell (shift-add qty*price), set price, clear total.
// Latency: resp_valid 2 cycles after the accepting edge's cycle, 2+CW for a SELL that multiplies.
// Backpressure: single outstanding request; req_ready only in IDLE, response is a one-cycle pulse.
// Ports: req_* request in (valid/ready), resp_* one-cycle result, total running sum, empty per-item flags.
module fcims_multi #(
    parameter int NITEMS = 4,
    parameter int CW     = 4,
    parameter int PW     = 4,
    parameter int TW     = 8,
    parameter int IW     = (NITEMS > 1) ? $clog2(NITEMS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [IW-1:0]     req_item,
    input  logic [CW-1:0]     req_qty,
    input  logic [PW-1:0]     req_price,
    output logic              resp_valid,
    output logic [1:0]        resp_status,
    output logic [CW-1:0]     resp_count,
    output logic [PW+CW-1:0]  resp_cost,
    output logic [TW-1:0]     total,
    output logic [NITEMS-1:0] empty
);

    localparam logic [1:0] OP_RESTOCK = 2'b00;
    localparam logic [1:0] OP_SELL    = 2'b01;
    localparam logic [1:0] OP_SETP    = 2'b10;
    localparam logic [1:0] OP_CLEAR   = 2'b11;

    localparam logic [1:0] ST_OK     = 2'b00;
    localparam logic [1:0] ST_REJECT = 2'b01;
    localparam logic [1:0] ST_COVF   = 2'b10;
    localparam logic [1:0] ST_TOVF   = 2'b11;

    localparam int MW = (CW > 1) ? $clog2(CW) : 1;
    localparam int XW = PW + CW;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_MUL, S_RESP} state_t;

    state_t r_state, w_state_nxt;

    logic [1:0]    r_op;
    logic [IW-1:0] r_item;
    logic [CW-1:0] r_qty;
    logic [PW-1:0] r_price;

    logic [CW-1:0] r_count [NITEMS];
    logic [PW-1:0] r_ptab  [NITEMS];
    logic [TW-1:0] r_total;

    logic [XW-1:0] r_acc;
    logic [XW-1:0] r_mcand;
    logic [CW-1:0] r_mplier;
    logic [MW-1:0] r_mcnt;

    logic [1:0]    r_status;
    logic [CW-1:0] r_rcount;
    logic [XW-1:0] r_rcost;

    logic          w_item_bad;
    logic [CW-1:0] w_cur_cnt;
    logic [PW-1:0] w_cur_price;
    logic [CW:0]   w_rsum;
    logic          w_sell_ok;
    logic          w_mul_last;
    logic [XW-1:0] w_prod;
    logic [TW:0]   w_tsum;

    // Index range check only exists when the index field can address past the last slot.
    generate
        if ((1 << IW) > NITEMS) begin : g_item_chk
            assign w_item_bad = ({1'b0, r_item} >= (IW+1)'(NITEMS));
        end else begin : g_item_nochk
            assign w_item_bad = 1'b0;
        end
    endgenerate

    assign w_cur_cnt   = r_count[r_item];
    assign w_cur_price = r_ptab[r_item];
    assign w_rsum      = {1'b0, w_cur_cnt} + {1'b0, r_qty};
    assign w_sell_ok   = (r_qty <= w_cur_cnt);
    assign w_mul_last  = (r_mcnt == MW'(CW - 1));
    // Product including the final partial product, used on the MUL->RESP edge.
    assign w_prod      = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_tsum      = {1'b0, r_total} + (TW+1)'(w_prod);

    assign req_ready   = (r_state == S_IDLE);
    assign resp_valid  = (r_state == S_RESP);
    assign resp_status = r_status;
    assign resp_count  = r_rcount;
    assign resp_cost   = r_rcost;
    assign total       = r_total;

    always_comb begin
        empty = '0;
        for (int i = 0; i < NITEMS; i++) begin
            empty[i] = (r_count[i] == '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (req_valid) w_state_nxt = S_CHECK;
            S_CHECK: w_state_nxt = (!w_item_bad && r_op == OP_SELL && w_sell_ok) ? S_MUL : S_RESP;
            S_MUL:   if (w_mul_last) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // All commits happen on the edge that enters RESP, so total/empty are current during resp_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op     <= '0;
            r_item   <= '0;
            r_qty    <= '0;
            r_price  <= '0;
            r_total  <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_mcnt   <= '0;
            r_status <= ST_OK;
            r_rcount <= '0;
            r_rcost  <= '0;
            for (int i = 0; i < NITEMS; i++) begin
                r_count[i] <= '0;
                r_ptab[i]  <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op    <= req_op;
                        r_item  <= req_item;
                        r_qty   <= req_qty;
                        r_price <= req_price;
                    end
                end
                S_CHECK: begin
                    r_rcost  <= '0;
                    r_status <= ST_OK;
                    r_rcount <= w_cur_cnt;
                    if (w_item_bad) begin
                        r_status <= ST_REJECT;
                        r_rcount <= '0;
                    end else begin
                        case (r_op)
                            OP_RESTOCK: begin
                                if (w_rsum[CW]) begin
                                    r_status <= ST_COVF;
                                end else begin
                                    r_count[r_item] <= w_rsum[CW-1:0];
                                    r_rcount        <= w_rsum[CW-1:0];
                                end
                            end
                            OP_SELL: begin
                                if (!w_sell_ok) begin
                                    r_status <= ST_REJECT;
                                end else begin
                                    r_acc    <= '0;
                                    r_mcand  <= XW'(w_cur_price);
                                    r_mplier <= r_qty;
                                    r_mcnt   <= '0;
                                end
                            end
                            OP_SETP:  r_ptab[r_item] <= r_price;
                            OP_CLEAR: r_total <= '0;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    r_acc    <= w_prod;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_mcnt   <= r_mcnt + 1'b1;
                    if (w_mul_last) begin
                        r_rcost <= w_prod;
                        if (w_tsum[TW]) begin
                            r_status <= ST_TOVF;
                            r_rcount <= w_cur_cnt;
                        end else begin
                            r_status        <= ST_OK;
                            r_count[r_item] <= w_cur_cnt - r_qty;
                            r_rcount        <= w_cur_cnt - r_qty;
                            r_total         <= w_tsum[TW-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fcims_multi.sv
module tb_fcims_multi;

    logic       clk;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [1:0] req_item;
    logic [3:0] req_qty;
    logic [3:0] req_price;
    logic       resp_valid;
    logic [1:0] resp_status;
    logic [3:0] resp_count;
    logic [7:0] resp_cost;
    logic [7:0] total;
    logic [3:0] empty;

    fcims_multi #(.NITEMS(4), .CW(4), .PW(4), .TW(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_item(req_item), .req_qty(req_qty), .req_price(req_price),
        .resp_valid(resp_valid), .resp_status(resp_status), .resp_count(resp_count),
        .resp_cost(resp_cost), .total(total), .empty(empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int st;
        int cnt;
        int cost;   // -1: not checked
        int tot;
        int emp;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_total = 0;
    int   n_bad   = 0;

    localparam int RESTOCK = 0, SELL = 1, SETP = 2, CLR = 3;

    task automatic chk(input string tag, input int obs, input int expv);
        n_total++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Drive one request, push its expectation, then wait for the response and compare.
    task automatic txn(input string tag, input int op, input int item, input int qty, input int price,
                       input int st, input int cnt, input int cost, input int tot, input int emp, input int cyc);
        exp_t e;
        exp_t g;
        int   n;
        e.st = st; e.cnt = cnt; e.cost = cost; e.tot = tot; e.emp = emp; e.cyc = cyc;
        @(negedge clk);
        req_op    = 2'(op);
        req_item  = 2'(item);
        req_qty   = 4'(qty);
        req_price = 4'(price);
        req_valid = 1'b1;
        chk({tag, ".ready"}, int'(req_ready), 1);
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!resp_valid) begin
            chk({tag, ".timeout"}, 0, 1);
        end else if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 0, 1);
        end else begin
            g = sb.pop_front();
            chk({tag, ".cycle"},  n,                 g.cyc);
            chk({tag, ".status"}, int'(resp_status), g.st);
            chk({tag, ".count"},  int'(resp_count),  g.cnt);
            if (g.cost >= 0) chk({tag, ".cost"}, int'(resp_cost), g.cost);
            chk({tag, ".total"},  int'(total),       g.tot);
            chk({tag, ".empty"},  int'(empty),       g.emp);
        end
        @(posedge clk);
        #1;
        chk({tag, ".pulse_end"}, int'(resp_valid), 0);
        chk({tag, ".ready_again"}, int'(req_ready), 1);
    endtask

    initial begin
        int seen;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_item  = '0;
        req_qty   = '0;
        req_price = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst.empty",  int'(empty), 4'b1111);
        chk("rst.total",  int'(total), 0);
        chk("rst.ready",  int'(req_ready), 1);
        chk("rst.rvalid", int'(resp_valid), 0);
        chk("rst.status", int'(resp_status), 0);
        chk("rst.cost",   int'(resp_cost), 0);

        //   tag     op       item qty price   st cnt cost  tot  emp      cyc
        txn("setp2", SETP,    2,   0,  9,      0, 0,  0,    0,   4'b1111, 2);
        txn("rs2",   RESTOCK, 2,   7,  0,      0, 7,  0,    0,   4'b1011, 2);
        txn("sell2", SELL,    2,   3,  0,      0, 4,  27,   27,  4'b1011, 6);
        txn("rej2",  SELL,    2,   5,  0,      1, 4,  -1,   27,  4'b1011, 2);
        txn("rs0a",  RESTOCK, 0,   8,  0,      0, 8,  0,    27,  4'b1010, 2);
        txn("rs0ov", RESTOCK, 0,   10, 0,      2, 8,  0,    27,  4'b1010, 2);
        txn("rs0b",  RESTOCK, 0,   7,  0,      0, 15, 0,    27,  4'b1010, 2);
        txn("rs0z",  RESTOCK, 0,   0,  0,      0, 15, 0,    27,  4'b1010, 2);
        txn("clr0",  CLR,     0,   0,  0,      0, 15, 0,    0,   4'b1010, 2);
        txn("setp1", SETP,    1,   0,  15,     0, 0,  0,    0,   4'b1010, 2);
        txn("setp3", SETP,    3,   0,  5,      0, 0,  0,    0,   4'b1010, 2);
        txn("rs1",   RESTOCK, 1,   15, 0,      0, 15, 0,    0,   4'b1000, 2);
        txn("sell1", SELL,    1,   15, 0,      0, 0,  225,  225, 4'b1010, 6);
        txn("rs3",   RESTOCK, 3,   5,  0,      0, 5,  0,    225, 4'b0010, 2);
        txn("sell3", SELL,    3,   5,  0,      0, 0,  25,   250, 4'b1010, 6);
        txn("rs1b",  RESTOCK, 1,   2,  0,      0, 2,  0,    250, 4'b1000, 2);
        txn("tovf",  SELL,    1,   1,  0,      3, 2,  15,   250, 4'b1000, 6);
        txn("sellq0",SELL,    1,   0,  0,      0, 2,  0,    250, 4'b1000, 6);
        txn("clr1",  CLR,     1,   0,  0,      0, 2,  0,    0,   4'b1000, 2);

        // Reset in the third MUL cycle of a SELL, with req_valid held high throughout.
        @(negedge clk);
        req_op = 2'(SELL); req_item = 2'd2; req_qty = 4'd1; req_valid = 1'b1;
        chk("abort.ready", int'(req_ready), 1);
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("abort.busy_ready", int'(req_ready), 0);
            chk("abort.busy_rvalid", int'(resp_valid), 0);
            @(posedge clk);
        end
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort.rst_empty",  int'(empty), 4'b1111);
        chk("abort.rst_total",  int'(total), 0);
        chk("abort.rst_rvalid", int'(resp_valid), 0);
        chk("abort.rst_count",  int'(resp_count), 0);
        chk("abort.rst_cost",   int'(resp_cost), 0);
        chk("abort.rst_status", int'(resp_status), 0);
        req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("abort.ready_after", int'(req_ready), 1);
        seen = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen++;
        end
        chk("abort.no_pulse", seen, 0);

        // Counts and prices were cleared: restock then sell at price 0.
        txn("post_rs", RESTOCK, 2, 2, 0,       0, 2,  0,    0,   4'b1011, 2);
        txn("post_sl", SELL,    2, 2, 0,       0, 0,  0,    0,   4'b1111, 6);

        chk("sb.drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fcims_multi.md
FCIMS_MULTI -- requirements
Module: fcims_multi

Interface
REQ-001 Parameter NITEMS, default 4: number of item slots.
REQ-002 Parameter CW, default 4: width of the count and quantity fields.
REQ-003 Parameter PW, default 4: width of the unit price field.
REQ-004 Parameter TW, default 8: width of the running total; TW SHALL be >= PW+CW.
REQ-005 Parameter IW, default clog2(NITEMS) (minimum 1): width of the item index.
REQ-006 Port clk, in, 1: the single clock; all state changes on its rising edge.
REQ-007 Port reset_n, in, 1: asynchronous, active-low reset.
REQ-008 Port req_valid, in, 1: a request is presented.
REQ-009 Port req_ready, out, 1: the block accepts a request this cycle.
REQ-010 Port req_op, in, 2: operation code; 00 RESTOCK, 01 SELL, 10 SET_PRICE, 11 CLEAR_TOTAL.
REQ-011 Port req_item, in, IW: target item index.
REQ-012 Port req_qty, in, CW: quantity for RESTOCK and SELL.
REQ-013 Port req_price, in, PW: unit price for SET_PRICE.
REQ-014 Port resp_valid, out, 1: one-cycle completion pulse.
REQ-015 Port resp_status, out, 2: result code; 00 OK, 01 REJECT, 10 COUNT_OVF, 11 TOTAL_OVF.
REQ-016 Port resp_count, out, CW: count of the target item after the operation.
REQ-017 Port resp_cost, out, PW+CW: qty*price of a SELL; 0 for all other operations.
REQ-018 Port total, out, TW: registered running sales total.
REQ-019 Port empty, out, NITEMS: empty[i]=1 when count[i]==0, combinational from registers.

Function
REQ-020 Storage SHALL be NITEMS count registers (CW bits), NITEMS price registers (PW bits) and one total register (TW bits).
REQ-021 FSM states SHALL be IDLE, CHECK, MUL, RESP.
REQ-022 req_ready SHALL be 1 only in IDLE; a request is accepted on an edge where req_valid&&req_ready, and its fields are latched at that edge.
REQ-023 IDLE SHALL go to CHECK on acceptance, otherwise stay in IDLE.
REQ-024 CHECK (1 cycle) SHALL evaluate the latched request as follows:
- req_item>=NITEMS: REJECT.
- RESTOCK: if count+qty>2^CW-1, COUNT_OVF with no change; else count+=qty, OK.
- SET_PRICE: price[item]=req_price, OK.
- CLEAR_TOTAL: total=0, OK.
- SELL with qty>count: REJECT with no change.
- SELL with qty<=count: go to MUL.
- Every other outcome: go to RESP.
REQ-025 MUL SHALL be a shift-add multiplier of qty by price running exactly CW cycles, then go to RESP.
REQ-026 On the MUL->RESP edge, if total+cost>2^TW-1, status SHALL be TOTAL_OVF and neither count nor total changes; otherwise count-=qty, total+=cost, status OK.
REQ-027 RESP SHALL assert resp_valid for exactly one cycle, then go to IDLE; resp_* SHALL be valid only while resp_valid=1 and there is no response backpressure.
REQ-028 Latency, counting the accepting edge as cycle 0:
- resp_valid high in cycle 2 for non-SELL and rejected SELL.
- resp_valid high in cycle 2+CW for a SELL that reaches MUL.
- req_ready high again in the cycle after RESP.
REQ-029 Register updates SHALL become visible at the edge entering RESP, so total and empty already reflect the operation while resp_valid=1.
REQ-030 Boundary results:
- SELL qty=0 or price=0: OK, cost 0, no change.
- SELL qty==count: count 0, empty bit sets.
- RESTOCK qty=0: OK.
- Arithmetic SHALL never wrap; overflow always rejects.
REQ-031 Rejected operations SHALL leave every count, price and total register unchanged.

Reset
REQ-032 reset_n=0 SHALL immediately force, asynchronously:
- state IDLE, all counts, prices and total 0, resp_valid 0, resp_status 00, resp_count 0, resp_cost 0, empty all ones.
REQ-033 Reset during CHECK or MUL SHALL abort the operation with no commit and no resp_valid pulse.
REQ-034 req_ready SHALL be 1 in the first cycle after reset_n deasserts.

Verification (NITEMS=4, CW=4, PW=4, TW=8)
REQ-035 Reset release -> empty=1111, total=0, req_ready=1, resp_valid=0.
REQ-036 SET_PRICE item2 price 9; RESTOCK item2 qty 7; SELL item2 qty 3 -> SELL response in cycle 6 with status 00, cost 27, count 4, total 27, empty=1111 then 1011 after the restock.
REQ-037 With count[2]=4, SELL item2 qty 5 -> response in cycle 2, status 01, count 4, total unchanged.
REQ-038 With count[0]=8, RESTOCK item0 qty 10 -> status 10, count 8; then RESTOCK qty 7 -> status 00, count 15.
REQ-039 With total=250 and price[1]=15, SELL item1 qty 1 -> status 11, cost 15, total 250, count unchanged; then CLEAR_TOTAL -> total 0.
REQ-040 reset_n pulsed low in the 3rd MUL cycle of a SELL -> no resp_valid pulse, all registers 0, req_ready=1 after release; req_valid held high during CHECK/MUL -> no second acceptance.
